// File: rtl/vjtag_debug_host_shifter_if.sv
// Command/response bus of the virtual-JTAG host shifter.
// A transfer happens on a clk edge where valid && ready; the source holds its payload stable while valid is high.
interface vjtag_debug_host_shifter_if #(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = 38
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                cmd_skip_ir;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_dr;
  logic [IR_WIDTH-1:0] rsp_ir_out;

  modport master (
    output cmd_valid, cmd_ir, cmd_dr, cmd_skip_ir, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_dr, cmd_skip_ir, rsp_ready,
    output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
  );
endinterface

// File: rtl/vjtag_debug_host_shifter.sv
// Host-side virtual-JTAG initiator: turns one IR/DR command into a full
// UIR/CDR/SDR/UDR/RTI sequence with generated tck and returns the captured tdo bits.
module vjtag_debug_host_shifter #(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = 38,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  vjtag_debug_host_shifter_if.slave bus,
  output logic                vj_tck,
  output logic                vj_tdi,
  input  logic                vj_tdo,
  output logic [IR_WIDTH-1:0] vj_ir_in,
  input  logic [IR_WIDTH-1:0] vj_ir_out,
  output logic                vj_uir,
  output logic                vj_cdr,
  output logic                vj_sdr,
  output logic                vj_udr,
  output logic                vj_rti,
  output logic [2:0]          dbg_state_o
);

  localparam int HW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int PW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [HW-1:0] HMAX = HW'(TCK_DIV - 1);
  localparam logic [PW-1:0] PMAX = PW'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UIR  = 3'd1,
    S_CDR  = 3'd2,
    S_SDR  = 3'd3,
    S_UDR  = 3'd4,
    S_RTI  = 3'd5,
    S_RESP = 3'd6
  } state_t;

  state_t              state_q;
  logic [HW-1:0]       hcnt_q;
  logic [PW-1:0]       pcnt_q;
  logic                tck_q;
  logic                tdi_q;
  logic [DR_WIDTH-1:0] sh_q;
  logic [DR_WIDTH-1:0] cap_q;
  logic [IR_WIDTH-1:0] ir_in_q;
  logic [IR_WIDTH-1:0] rsp_ir_q;
  logic                uir_q, cdr_q, sdr_q, udr_q, rti_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      hcnt_q      <= '0;
      pcnt_q      <= '0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      sh_q        <= '0;
      cap_q       <= '0;
      ir_in_q     <= '0;
      rsp_ir_q    <= '0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            sh_q        <= bus.cmd_dr;
            tck_q       <= 1'b0;
            hcnt_q      <= '0;
            pcnt_q      <= '0;
            if (bus.cmd_skip_ir) begin
              state_q <= S_CDR;
              cdr_q   <= 1'b1;
            end else begin
              state_q <= S_UIR;
              uir_q   <= 1'b1;
              ir_in_q <= bus.cmd_ir;
            end
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          if (hcnt_q == HMAX) begin
            hcnt_q <= '0;
            tck_q  <= ~tck_q;
            // tdo is taken on the edge that raises tck, before the slave shifts
            if (!tck_q && state_q == S_SDR) cap_q <= {vj_tdo, cap_q[DR_WIDTH-1:1]};
            if (tck_q) begin
              case (state_q)
                S_UIR: begin
                  uir_q   <= 1'b0;
                  cdr_q   <= 1'b1;
                  state_q <= S_CDR;
                end
                S_CDR: begin
                  cdr_q    <= 1'b0;
                  sdr_q    <= 1'b1;
                  rsp_ir_q <= vj_ir_out;
                  tdi_q    <= sh_q[0];
                  sh_q     <= sh_q >> 1;
                  pcnt_q   <= '0;
                  state_q  <= S_SDR;
                end
                S_SDR: begin
                  if (pcnt_q == PMAX) begin
                    sdr_q   <= 1'b0;
                    udr_q   <= 1'b1;
                    tdi_q   <= 1'b0;
                    state_q <= S_UDR;
                  end else begin
                    pcnt_q <= pcnt_q + PW'(1);
                    tdi_q  <= sh_q[0];
                    sh_q   <= sh_q >> 1;
                  end
                end
                S_UDR: begin
                  udr_q   <= 1'b0;
                  rti_q   <= 1'b1;
                  state_q <= S_RTI;
                end
                S_RTI: begin
                  rti_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
                end
                default: state_q <= S_IDLE;
              endcase
            end
          end else begin
            hcnt_q <= hcnt_q + HW'(1);
          end
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_dr     = cap_q;
  assign bus.rsp_ir_out = rsp_ir_q;
  assign vj_tck         = tck_q;
  assign vj_tdi         = tdi_q;
  assign vj_ir_in       = ir_in_q;
  assign vj_uir         = uir_q;
  assign vj_cdr         = cdr_q;
  assign vj_sdr         = sdr_q;
  assign vj_udr         = udr_q;
  assign vj_rti         = rti_q;
  assign dbg_state_o    = state_q;

endmodule
